aes_cbc_ctrl: RTL and testbench

CBC-mode sequencer that drives the single-block AES core from its initiator side. It accepts a key/IV session and a valid/ready stream of 128-bit blocks. For each block it issues one start to the core, waits for the core's done pulse, applies the CBC chaining XOR, and returns results on a valid/ready output stream. It sits between the bus-facing data buffers and the AES core instance in the crypto subsystem.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_cbc_ctrl.sv | 137 +++++++++++++
 tb/tb_aes_cbc_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES CBC sequencer: block width and FSM state encoding.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] blk_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/aes_cbc_ctrl.sv
// CBC-mode sequencer: one block in flight, issuing a start to the single-block AES
// core, applying the chaining XOR and returning the result on a valid/ready stream.
module aes_cbc_ctrl
  import aes_pkg::*;
(
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_fInit,
  input  logic                 i_fDec,
  input  logic [AES_BLK_W-1:0] i_Key,
  input  logic [AES_BLK_W-1:0] i_Iv,
  input  logic                 i_fInValid,
  output logic                 o_fInReady,
  input  logic [AES_BLK_W-1:0] i_InData,
  input  logic                 i_fInLast,
  output logic                 o_fOutValid,
  input  logic                 i_fOutReady,
  output logic [AES_BLK_W-1:0] o_OutData,
  output logic                 o_fOutLast,
  output logic                 o_fBusy,
  output logic                 o_AesFStart,
  output logic                 o_AesFDec,
  output logic [AES_BLK_W-1:0] o_AesKey,
  output logic [AES_BLK_W-1:0] o_AesText,
  input  logic                 i_AesFDone,
  input  logic [AES_BLK_W-1:0] i_AesText
);

  state_e state_q, state_d;
  blk_t   key_q, key_d;
  blk_t   chain_q, chain_d;
  blk_t   cipher_q, cipher_d;
  blk_t   text_q, text_d;
  blk_t   out_q, out_d;
  logic   dec_q, dec_d;
  logic   last_q, last_d;
  logic   in_rdy_q, out_vld_q, start_q, busy_q;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
    state_d  = state_q;
    key_d    = key_q;
    chain_d  = chain_q;
    cipher_d = cipher_q;
    text_d   = text_q;
    out_d    = out_q;
    dec_d    = dec_q;
    last_d   = last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_fInit) begin
          key_d   = i_Key;
          chain_d = i_Iv;
          dec_d   = i_fDec;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (i_fInValid) begin
          if (dec_q) begin
            text_d   = i_InData;
            cipher_d = i_InData;
          end else begin
            text_d   = i_InData ^ chain_q;
          end
          last_d  = i_fInLast;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_AesFDone) begin
          if (dec_q) begin
            out_d   = i_AesText ^ chain_q;
            chain_d = cipher_q;
          end else begin
            out_d   = i_AesText;
            chain_d = i_AesText;
          end
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        // Result register is cleared on handoff so the output bus reads zero when idle.
        if (i_fOutReady) begin
          out_d   = '0;
          state_d = last_q ? ST_IDLE : ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so the core-facing key/text read zero after reset.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      chain_q   <= '0;
      cipher_q  <= '0;
      text_q    <= '0;
      out_q     <= '0;
      dec_q     <= 1'b0;
      last_q    <= 1'b0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      key_q     <= key_d;
      chain_q   <= chain_d;
      cipher_q  <= cipher_d;
      text_q    <= text_d;
      out_q     <= out_d;
      dec_q     <= dec_d;
      last_q    <= last_d;
      in_rdy_q  <= (state_d == ST_READY);
      out_vld_q <= (state_d == ST_OUT);
      start_q   <= (state_d == ST_START);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign o_fInReady  = in_rdy_q;
  assign o_fOutValid = out_vld_q;
  assign o_OutData   = out_q;
  assign o_fOutLast  = out_vld_q & last_q;
  assign o_fBusy     = busy_q;
  assign o_AesFStart = start_q;
  assign o_AesFDec   = dec_q;
  assign o_AesKey    = key_q;
  assign o_AesText   = text_q;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Self-checking bench for aes_cbc_ctrl with a behavioural AES core stand-in and CBC reference model.
module tb_aes_cbc_ctrl;
  import aes_pkg::*;

  localparam blk_t NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam blk_t NIST_IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam blk_t P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam blk_t P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam blk_t C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam blk_t C2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam blk_t X1 = P1 ^ NIST_IV;
  localparam blk_t X2 = P2 ^ C1;
  localparam blk_t FAKE_C = {4{32'h5a3c96e1}};

  logic clk, rst_n;
  logic init, dec, in_valid, in_last, in_ready, out_valid, out_ready, out_last, busy;
  logic aes_start, aes_dec, aes_done;
  blk_t key, iv, in_data, out_data, aes_key, aes_text_o, aes_text_i;

  logic core_done, spur_done;
  blk_t core_text, spur_text;
  assign aes_done   = core_done | spur_done;
  assign aes_text_i = spur_done ? spur_text : core_text;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0, start_width_err = 0, stab_err = 0, done_timing_err = 0;
  int extra_lat = 0;
  logic start_prev = 1'b0;
  blk_t stim_q[$];
  blk_t exp_q[$];

  aes_cbc_ctrl dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_fInit(init), .i_fDec(dec), .i_Key(key), .i_Iv(iv),
    .i_fInValid(in_valid), .o_fInReady(in_ready), .i_InData(in_data), .i_fInLast(in_last),
    .o_fOutValid(out_valid), .i_fOutReady(out_ready), .o_OutData(out_data),
    .o_fOutLast(out_last), .o_fBusy(busy), .o_AesFStart(aes_start), .o_AesFDec(aes_dec),
    .o_AesKey(aes_key), .o_AesText(aes_text_o), .i_AesFDone(aes_done), .i_AesText(aes_text_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic blk_t rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Block cipher stand-in: real AES results for the reference vectors, an invertible mix otherwise.
  function automatic blk_t core_fn(input blk_t k, input logic d, input blk_t x);
    blk_t t;
    if (k == NIST_KEY) begin
      if (!d && x == X1) return C1;
      if (!d && x == X2) return C2;
      if (d && x == C1) return X1;
      if (d && x == C2) return X2;
    end
    if (!d) begin
      t = x ^ k;
      return {t[114:0], t[127:115]} ^ FAKE_C;
    end
    t = x ^ FAKE_C;
    return {t[12:0], t[127:13]} ^ k;
  endfunction

  task automatic cbc_model(input blk_t k, input blk_t v, input logic d);
    blk_t chain = v;
    blk_t r;
    exp_q.delete();
    foreach (stim_q[i]) begin
      if (!d) begin
        r = core_fn(k, 1'b0, stim_q[i] ^ chain);
        chain = r;
      end else begin
        r = core_fn(k, 1'b1, stim_q[i]) ^ chain;
        chain = stim_q[i];
      end
      exp_q.push_back(r);
    end
  endtask

  // Core model: latches operands on start, watches they stay put, pulses done after the latency.
  logic busy_m = 1'b0;
  int   cnt_m = 0;
  blk_t k_m, t_m;
  logic d_m;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m = 1'b0;
      cnt_m = 0;
      core_done = 1'b0;
      core_text = '0;
    end else begin
      if (core_done) begin
        core_done = 1'b0;
        if (out_valid !== 1'b1) done_timing_err++;
      end
      if (busy_m) begin
        if (aes_key !== k_m || aes_text_o !== t_m || aes_dec !== d_m) stab_err++;
        cnt_m--;
        if (cnt_m <= 0) begin
          core_done = 1'b1;
          core_text = core_fn(k_m, d_m, t_m);
          busy_m = 1'b0;
        end
      end else if (aes_start === 1'b1) begin
        busy_m = 1'b1;
        k_m = aes_key;
        t_m = aes_text_o;
        d_m = aes_dec;
        cnt_m = (aes_dec ? 21 : 11) + extra_lat;
      end
    end
  end

  always @(negedge clk) begin
    if (aes_start === 1'b1) begin
      start_cnt++;
      if (start_prev) start_width_err++;
    end
    start_prev = aes_start;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    init = 0; dec = 0; key = '0; iv = '0;
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
    spur_done = 0; spur_text = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic init_session(input blk_t k, input blk_t v, input logic d);
    key = k; iv = v; dec = d; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic send_block(input blk_t data, input logic last, output bit to);
    int n = 0;
    to = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++; to = 1;
      $display("FAIL in_ready_timeout: got no ready expected ready within 300 cycles");
      return;
    end
    in_valid = 1'b1; in_data = data; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (aes_start !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: got %b expected 1", aes_start);
    end
  endtask

  task automatic wait_out(output bit to);
    int n = 0;
    to = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++; to = 1;
      $display("FAIL out_valid_timeout: got no valid expected valid within 300 cycles");
    end
  endtask

  task automatic recv_block(input int delay, output blk_t data, output logic last, output bit to);
    wait_out(to);
    if (to) return;
    repeat (delay) @(negedge clk);
    data = out_data; last = out_last;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_health(input string name);
    checks++;
    if (start_width_err !== 0 || stab_err !== 0 || done_timing_err !== 0) begin
      failures++;
      $display("FAIL %s_health: got width_err=%0d stab_err=%0d done_timing_err=%0d expected all 0",
               name, start_width_err, stab_err, done_timing_err);
    end
  endtask

  // Runs a full session over stim_q, comparing each result to exp_q.
  task automatic run_session(input string name, input blk_t k, input blk_t v, input logic d,
                             input bit rand_delay);
    int s0 = start_cnt;
    int n = stim_q.size();
    bit to;
    blk_t r;
    logic l;
    init_session(k, v, d);
    for (int i = 0; i < n; i++) begin
      send_block(stim_q[i], (i == n - 1), to);
      if (to) return;
      recv_block(rand_delay ? int'($urandom_range(0, 3)) : 0, r, l, to);
      if (to) return;
      checks++;
      if (r !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_data[%0d]: got %h expected %h", name, i, r, exp_q[i]);
      end
      checks++;
      if (l !== (i == n - 1) || aes_dec !== d) begin
        failures++;
        $display("FAIL %s_last_dec[%0d]: got last=%b dec=%b expected last=%b dec=%b",
                 name, i, l, aes_dec, (i == n - 1), d);
      end
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: got busy=%b ready=%b valid=%b expected 0 0 0",
               name, busy, in_ready, out_valid);
    end
    checks++;
    if (start_cnt - s0 !== n) begin
      failures++;
      $display("FAIL %s_start_count: got %0d expected %0d", name, start_cnt - s0, n);
    end
    check_health(name);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, out_valid, aes_start, busy, out_last, aes_dec} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000",
               {in_ready, out_valid, aes_start, busy, out_last, aes_dec});
    end
    checks++;
    if (out_data !== '0 || aes_key !== '0 || aes_text_o !== '0) begin
      failures++;
      $display("FAIL reset_data: got out=%h key=%h text=%h expected zeros",
               out_data, aes_key, aes_text_o);
    end
  endtask

  task automatic test_encrypt_vectors();
    stim_q = '{P1, P2};
    exp_q  = '{C1, C2};
    run_session("enc_vec", NIST_KEY, NIST_IV, 1'b0, 1'b0);
  endtask

  task automatic test_decrypt_vectors();
    stim_q = '{C1, C2};
    exp_q  = '{P1, P2};
    run_session("dec_vec", NIST_KEY, NIST_IV, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    bit to;
    blk_t r;
    logic l;
    int s0;
    init_session(NIST_KEY, NIST_IV, 1'b0);
    send_block(P1, 1'b0, to);
    if (to) return;
    wait_out(to);
    if (to) return;
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = rand128(); in_last = 1'b1;
      @(negedge clk);
      checks++;
      if (out_data !== C1 || out_valid !== 1'b1 || in_ready !== 1'b0 || start_cnt !== s0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got data=%h valid=%b ready=%b starts=%0d expected %h 1 0 %0d",
                 i, out_data, out_valid, in_ready, start_cnt, C1, s0);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    recv_block(0, r, l, to);
    if (to) return;
    send_block(P2, 1'b1, to);
    if (to) return;
    recv_block(0, r, l, to);
    if (to) return;
    checks++;
    if (r !== C2 || l !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: got %h last=%b expected %h last=1", r, l, C2);
    end
  endtask

  task automatic test_ignored();
    bit to;
    blk_t r;
    logic l;
    init_session(NIST_KEY, NIST_IV, 1'b0);
    spur_text = rand128(); spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL spurious_done: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    send_block(P1, 1'b0, to);
    if (to) return;
    repeat (3) @(negedge clk);
    key = rand128(); iv = rand128(); dec = 1'b1; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    checks++;
    if (aes_key !== NIST_KEY || aes_dec !== 1'b0) begin
      failures++;
      $display("FAIL init_in_wait: got key=%h dec=%b expected %h 0", aes_key, aes_dec, NIST_KEY);
    end
    recv_block(0, r, l, to);
    if (to) return;
    checks++;
    if (r !== C1) begin
      failures++;
      $display("FAIL ignored_blk1: got %h expected %h", r, C1);
    end
    send_block(P2, 1'b1, to);
    if (to) return;
    recv_block(0, r, l, to);
    if (to) return;
    checks++;
    if (r !== C2) begin
      failures++;
      $display("FAIL ignored_blk2_chain: got %h expected %h", r, C2);
    end
  endtask

  task automatic test_reset_mid_block();
    bit to;
    init_session(NIST_KEY, NIST_IV, 1'b0);
    send_block(P1, 1'b0, to);
    if (to) return;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, aes_start, busy, out_last, aes_dec} !== 6'b0 ||
        out_data !== '0 || aes_key !== '0 || aes_text_o !== '0) begin
      failures++;
      $display("FAIL mid_reset: got flags=%b out=%h key=%h text=%h expected all zero",
               {in_ready, out_valid, aes_start, busy, out_last, aes_dec}, out_data, aes_key, aes_text_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_encrypt_vectors();
  endtask

  task automatic test_random_sessions();
    blk_t k, v;
    logic d;
    int n;
    for (int s = 0; s < 6; s++) begin
      k = rand128(); v = rand128(); d = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      extra_lat = $urandom_range(0, 6);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(rand128());
      cbc_model(k, v, d);
      run_session($sformatf("rand%0d", s), k, v, d, 1'b1);
    end
    extra_lat = 0;
  endtask

  initial begin
    test_reset();
    test_encrypt_vectors();
    test_decrypt_vectors();
    test_backpressure();
    test_ignored();
    test_reset_mid_block();
    test_random_sessions();
    check_health("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
